// File: rtl/draw_pkg.sv
// Shared widths and FSM encoding for the rectangle draw path (scheduler, engine, game FSMs).
// Pure declarations: no logic, no latency, no flow control.
package draw_pkg;

   localparam int X_W   = 8;
   localparam int Y_W   = 7;
   localparam int DIM_W = 5;
   localparam int COL_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      ACK  = 2'd3
   } draw_state_e;

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_LOAD = LOAD;
   localparam logic [1:0] ST_RUN  = RUN;
   localparam logic [1:0] ST_ACK  = ACK;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit after last_grant, wrapping.
// Zero latency; no backpressure, valid simply reflects |req.
module rr_pick #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [2:0]         last_grant,
   output logic               valid,
   output logic [2:0]         index
);

   always_comb begin
      int                 cand;
      logic [NUM_REQ-1:0] shifted;
      valid   = 1'b0;
      index   = 3'd0;
      cand    = 0;
      shifted = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(last_grant) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         shifted = req >> cand;
         if (!valid && shifted[0]) begin
            valid = 1'b1;
            index = 3'(cand);
         end
      end
   end

endmodule

// File: rtl/draw_scheduler.sv
// Shares one rectangle engine among NUM_REQ requesters: IDLE grant -> 1-cycle LOAD -> RUN to done -> 1-cycle ACK.
// Grant-to-RUN is 2 cycles, ack 1 cycle after done; pause or busy holds requesters off (req stays high until ack).
module draw_scheduler
   import draw_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*X_W-1:0]   req_x,
   input  logic [NUM_REQ*Y_W-1:0]   req_y,
   input  logic [NUM_REQ*DIM_W-1:0] req_w,
   input  logic [NUM_REQ*DIM_W-1:0] req_h,
   input  logic [NUM_REQ*COL_W-1:0] req_c,
   input  logic                     pause,
   output logic [NUM_REQ-1:0]       ack,
   output logic                     busy,
   output logic [2:0]               grant_id,
   output logic [X_W-1:0]           eng_x,
   output logic [Y_W-1:0]           eng_y,
   output logic [DIM_W-1:0]         eng_w,
   output logic [DIM_W-1:0]         eng_h,
   output logic [COL_W-1:0]         eng_c,
   output logic                     eng_reset,
   output logic                     eng_enable,
   input  logic                     eng_done,
   output logic                     plot
);

   logic [1:0] state;
   logic [2:0] last_grant;
   logic       pick_vld;
   logic [2:0] pick_idx;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req        (req),
      .last_grant (last_grant),
      .valid      (pick_vld),
      .index      (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ST_IDLE;
         last_grant <= 3'(NUM_REQ - 1);
         grant_id   <= 3'd0;
         eng_x      <= '0;
         eng_y      <= '0;
         eng_w      <= '0;
         eng_h      <= '0;
         eng_c      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!pause && pick_vld) begin
                  grant_id <= pick_idx;
                  eng_x    <= req_x[pick_idx*X_W +: X_W];
                  eng_y    <= req_y[pick_idx*Y_W +: Y_W];
                  eng_w    <= req_w[pick_idx*DIM_W +: DIM_W];
                  eng_h    <= req_h[pick_idx*DIM_W +: DIM_W];
                  eng_c    <= req_c[pick_idx*COL_W +: COL_W];
                  state    <= ST_LOAD;
               end
            end
            ST_LOAD: state <= ST_RUN;
            ST_RUN: begin
               if (eng_done) state <= ST_ACK;
            end
            default: begin
               last_grant <= grant_id;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

   // Engine reset is the load strobe: held low by our own reset too, so an aborted draw never resumes.
   assign eng_reset  = reset & (state != ST_LOAD);
   assign eng_enable = (state == ST_RUN);
   assign plot       = (state == ST_RUN) & ~eng_done;
   assign busy       = (state != ST_IDLE);
   assign ack        = (state == ST_ACK) ? (NUM_REQ'(1) << grant_id) : '0;

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Shares one rectangle-drawing engine between NUM_REQ object requesters (player ship, bullets, enemies, erase passes).
- Round-robin grants one requester at a time and latches its rectangle (x, y, width, height, colour).
- Loads the rectangle into the engine by pulsing the engine's active-low reset, runs the engine until done, then acks the requester.
- Sits between the game-object FSMs and the draw engine/VGA adapter; `plot` drives the adapter's write strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  circuit clock
- reset  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester draw request; held high until ack
- req_x  in  NUM_REQ*8  flattened top-left x; slice i = [8i+7:8i]
- req_y  in  NUM_REQ*7  flattened top-left y
- req_w  in  NUM_REQ*5  flattened width (engine convention)
- req_h  in  NUM_REQ*5  flattened height (engine convention)
- req_c  in  NUM_REQ*3  flattened colour
- pause  in  1  when high, no new grant is issued; an in-flight operation completes
- ack  out  NUM_REQ  one-hot, one-cycle pulse when the granted rectangle is finished
- busy  out  1  high in LOAD, RUN and ACK
- grant_id  out  3  index of the current/last granted requester
- eng_x  out  8  latched x to engine x_in
- eng_y  out  7  latched y to engine y_in
- eng_w  out  5  latched width to engine
- eng_h  out  5  latched height to engine
- eng_c  out  3  latched colour to engine c_in
- eng_reset  out  1  active-low engine reset
- eng_enable  out  1  engine enable
- eng_done  in  1  engine done flag
- plot  out  1  pixel write strobe for the VGA adapter

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; latched x/y/w/h/c=0; ack=0; grant_id=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - eng_reset=0 (combinational: eng_reset = reset & (state!=LOAD)); eng_enable=0; plot=0; busy=0.
- IDLE:
  - If pause==0 and |req, pick the first set bit scanning from last_grant+1 upward with wrap.
  - Latch that requester's x, y, w, h, c into eng_* registers; grant_id=index; go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle): eng_reset=0 so the engine captures eng_x/eng_y and clears its counters; eng_enable=0; next state RUN.
- RUN:
  - eng_enable=1; plot = ~eng_done.
  - When eng_done==1, go to ACK. That cycle has plot=0 and eng_enable=1.
  - No timeout; the engine guarantees done.
- ACK (1 cycle): ack[grant_id]=1; eng_enable=0; last_grant=grant_id; next state IDLE.
- Latency:
  - req sampled in IDLE at edge k → LOAD during cycle k+1 → RUN from cycle k+2.
  - ack follows the done cycle by 1.
  - Minimum gap between consecutive grants: ACK + IDLE = 2 cycles with no plot.
- Requester contract:
  - Parameters must be stable from req rise until ack.
  - req must be low by the edge after ack; a registered drop satisfies this.
- req deasserted mid-operation: ignored; the operation completes and ack still pulses.
- req changes or pause rising during LOAD/RUN/ACK: no effect on the current operation.
- Fairness: with all req high, the grant order is 0,1,2,...,NUM_REQ-1,0.
- Reset mid-operation: immediate return to IDLE. No ack for the aborted rectangle; the requester re-requests.
- Simultaneous reset and eng_done: reset wins.
- eng_w/eng_h are passed through unmodified; the width/height convention is owned by the engine.

Decomposition:
- Shared package draw_pkg:
  - X_W=8, Y_W=7, DIM_W=5, COL_W=3.
  - State enum {IDLE, LOAD, RUN, ACK} (2-bit).
  - Also usable by the engine and the game FSMs.
- One sub-module rr_pick:
  - Combinational round-robin selector.
  - Inputs: req vector, last_grant. Outputs: valid, index.

Test Plan:
- Single request: req=0001, x=10, y=20, w=2, h=1, c=3'b100 → eng_reset low for exactly 1 cycle 1 cycle after req; plot high for engine pixel count; ack=0001 one cycle after eng_done; eng_x=10, eng_y=20 throughout.
- Fairness: req=1111 held, each dropped after its ack → grant_id sequence 0,1,2,3; four acks, each preceded by one LOAD pulse.
- Round-robin resume: last_grant=2, req=0101 → requester 0 granted next; then requester 2.
- Pause: pause=1 with req=0010 → state stays IDLE, no eng_reset pulse; pause=0 → LOAD next cycle. Pause raised during RUN → current ack still issued.
- Reset mid-RUN: assert reset 3 cycles into RUN → next cycle IDLE, plot=0, ack=0, eng_reset=0; after release requester 0 wins again.
- Requester drops req mid-RUN → operation completes and ack pulses once; no re-grant to that requester.
